up3_ctrl: RTL and testbench
===========================

# up3_ctrl

Control sequencer for the up3 8-bit accumulator processor. It drives the fetch/decode/execute cycle of the up3 datapath (PC, MAR, MDR, IR upper/lower, AC) by issuing one-hot control strobes from a 5-bit state machine. It also exports its state code so the board top can show it on the seven-segment displays. It sits between the datapath registers and the board-level debug wrapper, and replaces hand-built control decode.

## Interface

Parameters:
- none. Widths are fixed by the up3 datapath: 8-bit data and address, 5-bit state.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  8  IR upper byte from datapath; valid from the cycle after LOAD_H
- ac  in  8  accumulator value, used for conditional branches
- run  in  1  free-run enable; present only with UP3_CTRL_STEP_EN
- step  in  1  single-step request, level from debounced key; present only with UP3_CTRL_STEP_EN
- state  out  5  current state code
- fetch  out  1  memory read; MAR loads the address selected by mar_sel
- mar_sel  out  1  0 = PC, 1 = IR lower byte (value)
- load_h  out  1  IR upper byte <= MDR
- load_l  out  1  IR lower byte <= MDR
- incr_pc  out  1  PC <= PC + 1 (8-bit, wraps 0xFF -> 0x00)
- load_ac  out  1  AC <= ALU result
- alu_op  out  2  00 PASS_MDR, 01 PASS_VALUE, 10 ADD (AC+MDR), 11 SUB (AC-MDR); 8-bit, carry/borrow dropped
- store_mem  out  1  memory[MAR] <= AC
- load_pc  out  1  PC <= value
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- halted  out  1  high in HALT

## Operation

- Each instruction is two bytes: opcode, then value.
- Opcodes:
  - 0x00 LOADI: AC = value
  - 0x01 LOAD: AC = mem[value]
  - 0x02 STORE: mem[value] = AC
  - 0x03 ADD
  - 0x04 SUB
  - 0x05 JUMP
  - 0x06 JNEG: taken if ac[7] = 1
  - 0x07 JZ: taken if ac == 0
  - 0xFF HALT
  - All other opcodes execute as NOP.
- States and codes, with the strobes each asserts and its successor. All unlisted outputs are 0.
  - IDLE 0: no strobes -> FETCH_H.
  - FETCH_H 1: fetch, mar_sel=0 -> LOAD_H.
  - LOAD_H 2: load_h, incr_pc -> FETCH_L.
  - FETCH_L 3: fetch, mar_sel=0 -> LOAD_L.
  - LOAD_L 4: load_l, incr_pc -> DECODE.
  - DECODE 5: branches on opcode.
    - LOADI -> EX_LOADI
    - LOAD/ADD/SUB -> EX_MEM
    - STORE -> EX_STORE
    - JUMP, or taken JNEG/JZ -> EX_JUMP
    - HALT -> HALT
    - NOP or untaken branch: instr_done -> IDLE
  - EX_MEM 6: fetch, mar_sel=1 -> EX_ALU.
  - EX_ALU 7: load_ac; alu_op is 00 for LOAD, 10 for ADD, 11 for SUB; instr_done -> IDLE.
  - EX_LOADI 8: load_ac, alu_op=01, instr_done -> IDLE.
  - EX_STORE 9: store_mem, mar_sel=1, instr_done -> IDLE.
  - EX_JUMP 10: load_pc, instr_done -> IDLE.
  - HALT 31: halted; stays here until reset.
- Strobes are decoded combinationally from the state register, plus opcode in EX_ALU and DECODE. They never glitch across state boundaries in simulation.
- Unused state codes go to IDLE on the next edge.

## Timing

- Reset: state = IDLE (0), step edge register = 0. All outputs are 0 immediately and asynchronously.
- Memory model: MDR is valid on the edge after the fetch cycle.
- Instruction latency, counting IDLE, in cycles:
  - LOADI 7, LOAD/ADD/SUB 8, STORE 7, JUMP 7
  - Untaken branch or NOP 6
  - HALT reached 6 cycles after IDLE
- Branch condition is sampled from ac in DECODE only.
- Reset asserted mid-instruction aborts it. No partial strobe persists, and PC/IR contents are the datapath's concern.

## Configuration

- UP3_CTRL_STEP_EN defined:
  - run and step ports exist.
  - IDLE exits only when run=1, or on a step rising edge (step=1 and step_q=0, where step_q is step registered every cycle).
  - Step edges outside IDLE are ignored.
  - Holding step high yields exactly one instruction.
- UP3_CTRL_STEP_EN undefined:
  - Ports are absent.
  - IDLE always lasts exactly one cycle.

## Structure

- Package up3_pkg holds:
  - state_t: 5-bit enum with the codes above
  - opcode localparams OP_LOADI through OP_HALT
  - alu_op_t enum
- Sub-module up3_step_edge (rising-edge detector, async reset) is instantiated only under UP3_CTRL_STEP_EN.

## Test plan

- Reset mid-FETCH_L: assert reset -> state=0, all strobes 0 in the same cycle. Release -> FETCH_H after 1 cycle.
- Program LOADI 0x05, ADD 0x10 (mem[0x10]=0x03), STORE 0x20 -> mem[0x20]=0x08. instr_done pulses at cycles 7, 15, 22.
- JNEG with ac=0x80 -> EX_JUMP, load_pc=1, PC=value. With ac=0x7F -> DECODE pulses instr_done, no load_pc, 6-cycle instruction.
- JZ at ac=0x00 taken, at ac=0x01 untaken. SUB 0x01-0x02 -> AC=0xFF.
- Opcode 0xFF -> state=31, halted=1 held for 100 cycles, no strobes; reset clears it.
- With UP3_CTRL_STEP_EN, run=0: step held high 50 cycles -> exactly one instr_done, state parks at 0. Step pulse mid-instruction -> ignored.

Source files
------------

// File: rtl/up3_pkg.sv
// up3_pkg: shared state codes, opcodes and ALU select encodings for the up3 control sequencer.
package up3_pkg;

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_FETCH_H  = 5'd1,
        S_LOAD_H   = 5'd2,
        S_FETCH_L  = 5'd3,
        S_LOAD_L   = 5'd4,
        S_DECODE   = 5'd5,
        S_EX_MEM   = 5'd6,
        S_EX_ALU   = 5'd7,
        S_EX_LOADI = 5'd8,
        S_EX_STORE = 5'd9,
        S_EX_JUMP  = 5'd10,
        S_HALT     = 5'd31
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JUMP  = 8'h05;
    localparam logic [7:0] OP_JNEG  = 8'h06;
    localparam logic [7:0] OP_JZ    = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [1:0] {
        ALU_PASS_MDR   = 2'b00,
        ALU_PASS_VALUE = 2'b01,
        ALU_ADD        = 2'b10,
        ALU_SUB        = 2'b11
    } alu_op_t;

endpackage

// File: rtl/up3_ctrl_if.sv
// up3_ctrl_if: control strobes and status between the up3 sequencer and its datapath.
// There is no valid/ready pair here: every strobe is a single-cycle command that the datapath
// must act on at the next rising edge; opcode/ac are level inputs sampled by the sequencer.
interface up3_ctrl_if;
    logic [7:0] opcode;
    logic [7:0] ac;
    logic [4:0] state;
    logic       fetch;
    logic       mar_sel;
    logic       load_h;
    logic       load_l;
    logic       incr_pc;
    logic       load_ac;
    logic [1:0] alu_op;
    logic       store_mem;
    logic       load_pc;
    logic       instr_done;
    logic       halted;

    modport master (
        input  opcode, ac,
        output state, fetch, mar_sel, load_h, load_l, incr_pc, load_ac, alu_op,
               store_mem, load_pc, instr_done, halted
    );

    modport slave (
        output opcode, ac,
        input  state, fetch, mar_sel, load_h, load_l, incr_pc, load_ac, alu_op,
               store_mem, load_pc, instr_done, halted
    );
endinterface

// File: rtl/up3_step_edge.sv
// up3_step_edge: rising-edge detector for the debounced single-step key.
module up3_step_edge (
    input  logic clk,
    input  logic reset,
    input  logic step,
    output logic rise
);
    logic step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign rise = step & ~step_q;
endmodule

// File: rtl/up3_ctrl.sv
// up3_ctrl: fetch/decode/execute sequencer for the up3 8-bit accumulator datapath.
// Define UP3_CTRL_STEP_EN to add run/step ports that gate leaving IDLE.
module up3_ctrl
    import up3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
`ifdef UP3_CTRL_STEP_EN
    input  logic       run,
    input  logic       step,
`endif
    up3_ctrl_if.master bus
);

    state_t state_q;
    state_t state_n;
    logic   go;
    logic   branch_taken;
    logic   is_mem_op;

`ifdef UP3_CTRL_STEP_EN
    logic step_rise;

    up3_step_edge u_step_edge (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .rise  (step_rise)
    );

    // Step edges seen outside IDLE are simply not consulted.
    assign go = run | step_rise;
`else
    assign go = 1'b1;
`endif

    always_comb begin
        branch_taken = 1'b0;
        case (bus.opcode)
            OP_JUMP: branch_taken = 1'b1;
            OP_JNEG: branch_taken = bus.ac[7];
            OP_JZ:   branch_taken = (bus.ac == 8'h00);
            default: branch_taken = 1'b0;
        endcase
    end

    assign is_mem_op = (bus.opcode == OP_LOAD) || (bus.opcode == OP_ADD) ||
                       (bus.opcode == OP_SUB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Strobes depend only on state_q (plus opcode/ac), so reset clears them immediately.
    always_comb begin
        state_n        = state_q;
        bus.fetch      = 1'b0;
        bus.mar_sel    = 1'b0;
        bus.load_h     = 1'b0;
        bus.load_l     = 1'b0;
        bus.incr_pc    = 1'b0;
        bus.load_ac    = 1'b0;
        bus.alu_op     = ALU_PASS_MDR;
        bus.store_mem  = 1'b0;
        bus.load_pc    = 1'b0;
        bus.instr_done = 1'b0;
        bus.halted     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) state_n = S_FETCH_H;
            end
            S_FETCH_H: begin
                bus.fetch = 1'b1;
                state_n   = S_LOAD_H;
            end
            S_LOAD_H: begin
                bus.load_h  = 1'b1;
                bus.incr_pc = 1'b1;
                state_n     = S_FETCH_L;
            end
            S_FETCH_L: begin
                bus.fetch = 1'b1;
                state_n   = S_LOAD_L;
            end
            S_LOAD_L: begin
                bus.load_l  = 1'b1;
                bus.incr_pc = 1'b1;
                state_n     = S_DECODE;
            end
            S_DECODE: begin
                if (bus.opcode == OP_LOADI) begin
                    state_n = S_EX_LOADI;
                end else if (is_mem_op) begin
                    state_n = S_EX_MEM;
                end else if (bus.opcode == OP_STORE) begin
                    state_n = S_EX_STORE;
                end else if (branch_taken) begin
                    state_n = S_EX_JUMP;
                end else if (bus.opcode == OP_HALT) begin
                    state_n = S_HALT;
                end else begin
                    bus.instr_done = 1'b1;
                    state_n        = S_IDLE;
                end
            end
            S_EX_MEM: begin
                bus.fetch   = 1'b1;
                bus.mar_sel = 1'b1;
                state_n     = S_EX_ALU;
            end
            S_EX_ALU: begin
                bus.load_ac = 1'b1;
                if (bus.opcode == OP_ADD) begin
                    bus.alu_op = ALU_ADD;
                end else if (bus.opcode == OP_SUB) begin
                    bus.alu_op = ALU_SUB;
                end else begin
                    bus.alu_op = ALU_PASS_MDR;
                end
                bus.instr_done = 1'b1;
                state_n        = S_IDLE;
            end
            S_EX_LOADI: begin
                bus.load_ac    = 1'b1;
                bus.alu_op     = ALU_PASS_VALUE;
                bus.instr_done = 1'b1;
                state_n        = S_IDLE;
            end
            S_EX_STORE: begin
                bus.store_mem  = 1'b1;
                bus.mar_sel    = 1'b1;
                bus.instr_done = 1'b1;
                state_n        = S_IDLE;
            end
            S_EX_JUMP: begin
                bus.load_pc    = 1'b1;
                bus.instr_done = 1'b1;
                state_n        = S_IDLE;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_up3_ctrl.sv
// tb_up3_ctrl: drives up3_ctrl with a behavioural up3 datapath/memory and checks each instruction.
`timescale 1ns/1ps
module tb_up3_ctrl;
    import up3_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef UP3_CTRL_STEP_EN
    logic run = 1'b1;
    logic step = 1'b0;
`endif

    up3_ctrl_if bus ();

    up3_ctrl dut (
        .clk   (clk),
        .reset (reset),
`ifdef UP3_CTRL_STEP_EN
        .run   (run),
        .step  (step),
`endif
        .bus   (bus)
    );

    // ---------------- datapath + memory model ----------------
    logic [7:0] mem [256];
    logic [7:0] pc, mar, mdr, ir_h, ir_l, ac_r, alu_y;
    logic       tb_we = 1'b0;
    logic [7:0] tb_wa = 8'h00;
    logic [7:0] tb_wd = 8'h00;
    logic [11:0] strb;

    always_comb begin
        case (bus.alu_op)
            2'b00:   alu_y = mdr;
            2'b01:   alu_y = ir_l;
            2'b10:   alu_y = ac_r + mdr;
            default: alu_y = ac_r - mdr;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= 8'h00; mar <= 8'h00; mdr <= 8'h00;
            ir_h <= 8'h00; ir_l <= 8'h00; ac_r <= 8'h00;
            if (tb_we) mem[tb_wa] <= tb_wd;
        end else begin
            if (bus.fetch) begin
                mar <= bus.mar_sel ? ir_l : pc;
                mdr <= mem[bus.mar_sel ? ir_l : pc];
            end
            if (bus.load_h)    ir_h <= mdr;
            if (bus.load_l)    ir_l <= mdr;
            if (bus.incr_pc)   pc   <= pc + 8'd1;
            if (bus.load_pc)   pc   <= ir_l;
            if (bus.load_ac)   ac_r <= alu_y;
            if (bus.store_mem) mem[bus.mar_sel ? ir_l : mar] <= ac_r;
        end
    end

    assign bus.opcode = ir_h;
    assign bus.ac     = ac_r;
    assign strb = {bus.fetch, bus.mar_sel, bus.load_h, bus.load_l, bus.incr_pc, bus.load_ac,
                   bus.alu_op, bus.store_mem, bus.load_pc, bus.instr_done, bus.halted};

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];   // {latency[3:0], ac[7:0], pc[7:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] lat, input logic [7:0] acx, input logic [7:0] pcx);
        exp_q.push_back({lat, acx, pcx});
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_mem(input logic [7:0] a, input logic [7:0] d);
        tb_wa = a; tb_wd = d; tb_we = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] op, input logic [7:0] val);
        write_mem(a, op);
        write_mem(a + 8'd1, val);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs from a just-released reset (state IDLE counts as cycle 1 of the first instruction).
    task automatic run_prog(input string tag, input int n_instr, input int budget,
                            input bit expect_halt);
        int cyc = 0;
        int done_cnt = 0;
        bit pend = 1'b0;
        bit finished = 1'b0;
        logic [19:0] cur = '0;
        for (int t = 0; t < budget; t++) begin
            if (pend) begin
                check($sformatf("%s_ac%0d", tag, done_cnt), ac_r, cur[15:8]);
                check($sformatf("%s_pc%0d", tag, done_cnt), pc, cur[7:0]);
                pend = 1'b0;
                if (done_cnt == n_instr && !expect_halt) begin
                    finished = 1'b1;
                    break;
                end
            end
            cyc++;
            if (bus.halted) begin
                check($sformatf("%s_halt_lat", tag), cyc, 7);
                check($sformatf("%s_halt_cnt", tag), done_cnt, n_instr);
                finished = 1'b1;
                break;
            end
            if (bus.instr_done) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_unexpected_done", tag), 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    done_cnt++;
                    check($sformatf("%s_lat%0d", tag, done_cnt), cyc, {28'd0, cur[19:16]});
                    pend = 1'b1;
                end
                cyc = 0;
            end
            @(negedge clk);
        end
        if (!finished) check($sformatf("%s_timeout", tag), 0, 1);
        check($sformatf("%s_q_empty", tag), exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] op, val, ac0, m40;
        logic [3:0] lat;
        logic [7:0] acx, pcx, m40x;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] op, val, ac0, m40, input logic [3:0] lat,
                           input logic [7:0] acx, pcx, m40x);
        vec_t v;
        v.op = op; v.val = val; v.ac0 = ac0; v.m40 = m40;
        v.lat = lat; v.acx = acx; v.pcx = pcx; v.m40x = m40x;
        vecs.push_back(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bad;
        int found;
        int dones;

        //         op     val    ac0    m40    lat   ac     pc     m40 after
        add_vec(OP_LOADI, 8'h5A, 8'h11, 8'h00, 4'd7, 8'h5A, 8'h04, 8'h00);
        add_vec(OP_LOAD,  8'h40, 8'h11, 8'h77, 4'd8, 8'h77, 8'h04, 8'h77);
        add_vec(OP_ADD,   8'h40, 8'h05, 8'h03, 4'd8, 8'h08, 8'h04, 8'h03);
        add_vec(OP_ADD,   8'h40, 8'hF0, 8'h20, 4'd8, 8'h10, 8'h04, 8'h20);
        add_vec(OP_SUB,   8'h40, 8'h01, 8'h02, 4'd8, 8'hFF, 8'h04, 8'h02);
        add_vec(OP_STORE, 8'h40, 8'h33, 8'h00, 4'd7, 8'h33, 8'h04, 8'h33);
        add_vec(OP_JUMP,  8'h80, 8'h00, 8'h00, 4'd7, 8'h00, 8'h80, 8'h00);
        add_vec(OP_JNEG,  8'h90, 8'h80, 8'h00, 4'd7, 8'h80, 8'h90, 8'h00);
        add_vec(OP_JNEG,  8'h90, 8'h7F, 8'h00, 4'd6, 8'h7F, 8'h04, 8'h00);
        add_vec(OP_JNEG,  8'h66, 8'hFF, 8'h00, 4'd7, 8'hFF, 8'h66, 8'h00);
        add_vec(OP_JZ,    8'h50, 8'h00, 8'h00, 4'd7, 8'h00, 8'h50, 8'h00);
        add_vec(OP_JZ,    8'h50, 8'h01, 8'h00, 4'd6, 8'h01, 8'h04, 8'h00);
        add_vec(OP_JZ,    8'h50, 8'h80, 8'h00, 4'd6, 8'h80, 8'h04, 8'h00);
        add_vec(8'h08,    8'h40, 8'h22, 8'h00, 4'd6, 8'h22, 8'h04, 8'h00);
        add_vec(8'h42,    8'h40, 8'h22, 8'h00, 4'd6, 8'h22, 8'h04, 8'h00);
        add_vec(8'hFE,    8'h40, 8'h22, 8'h00, 4'd6, 8'h22, 8'h04, 8'h00);

        // Reset state
        #1;
        check("reset_state", bus.state, 0);
        check("reset_strobes", strb, 0);

        // Reset mid-FETCH_L aborts immediately and restarts from IDLE
        hold_reset();
        prog(8'h00, OP_LOADI, 8'h12);
        release_reset();
        found = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.state == 5'd3) begin found = 1; break; end
            @(negedge clk);
        end
        check("reach_fetch_l", found, 1);
        check("fetch_l_strobe", bus.fetch, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_state", bus.state, 0);
        check("async_reset_strobes", strb, 0);
        @(negedge clk);
        reset = 1'b0;
        check("released_idle", bus.state, 0);
        @(negedge clk);
        check("released_fetch_h", bus.state, 1);

        // Table-driven single instructions, each preceded by LOADI to set AC
        for (int i = 0; i < vecs.size(); i++) begin
            hold_reset();
            prog(8'h00, OP_LOADI, vecs[i].ac0);
            prog(8'h02, vecs[i].op, vecs[i].val);
            write_mem(8'h40, vecs[i].m40);
            push_exp(4'd7, vecs[i].ac0, 8'h02);
            push_exp(vecs[i].lat, vecs[i].acx, vecs[i].pcx);
            release_reset();
            run_prog($sformatf("vec%0d", i), 2, 40, 1'b0);
            check($sformatf("vec%0d_m40", i), mem[8'h40], vecs[i].m40x);
        end

        // Program: LOADI 5, ADD [0x10], STORE [0x20], HALT -> dones at 7, 15, 22
        hold_reset();
        prog(8'h00, OP_LOADI, 8'h05);
        prog(8'h02, OP_ADD,   8'h10);
        prog(8'h04, OP_STORE, 8'h20);
        prog(8'h06, OP_HALT,  8'h00);
        write_mem(8'h10, 8'h03);
        write_mem(8'h20, 8'h00);
        push_exp(4'd7, 8'h05, 8'h02);
        push_exp(4'd8, 8'h08, 8'h04);
        push_exp(4'd7, 8'h08, 8'h06);
        release_reset();
        run_prog("progA", 3, 60, 1'b1);
        check("progA_mem20", mem[8'h20], 8'h08);
        bad = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.state !== 5'd31 || strb !== 12'h001) bad++;
        end
        check("halt_hold", bad, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("halt_reset_state", bus.state, 0);
        check("halt_reset_halted", bus.halted, 0);

        // PC wrap: JUMP 0xFE, then LOADI at 0xFE/0xFF leaves PC at 0x00
        hold_reset();
        prog(8'h00, OP_JUMP,  8'hFE);
        prog(8'hFE, OP_LOADI, 8'h99);
        push_exp(4'd7, 8'h00, 8'hFE);
        push_exp(4'd7, 8'h99, 8'h00);
        release_reset();
        run_prog("pcwrap", 2, 40, 1'b0);

`ifdef UP3_CTRL_STEP_EN
        // Step held high: exactly one instruction, then park in IDLE
        hold_reset();
        run = 1'b0;
        step = 1'b0;
        prog(8'h00, OP_LOADI, 8'h44);
        prog(8'h02, OP_LOADI, 8'h55);
        release_reset();
        step = 1'b1;
        dones = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.instr_done) dones++;
        end
        check("step_hold_dones", dones, 1);
        check("step_hold_park", bus.state, 0);
        check("step_hold_ac", ac_r, 8'h44);

        // Second step pulse arriving mid-instruction is ignored
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        dones = 0;
        for (int t = 0; t < 30; t++) begin
            if (bus.instr_done) dones++;
            @(negedge clk);
        end
        check("step_mid_dones", dones, 1);
        check("step_mid_park", bus.state, 0);
        check("step_mid_ac", ac_r, 8'h55);
        run = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
